vdp_bus_master: RTL and testbench

- Bus initiator for the VDP host CPU port: drives mode[1:0], csw_n and csr_n, and drives or samples the 8-bit cd bus.
- Converts single-cycle request/ack transactions from internal logic into correctly timed VDP port accesses. Internal users are the init sequencer, self-test and the bench host model.
- Strobes are held long enough to pass the responder's pin filters. A full idle gap is inserted so the responder's chip-select-change detector re-arms between accesses.

---
 rtl/vdp_bus_master.sv | 184 ++++++++++++++++++
 tb/tb_vdp_bus_master.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdp_bus_master.sv
// VDP host-port bus initiator: turns one-cycle req/ack transactions into
// setup / strobe / hold / recovery timed accesses on mode, csw_n, csr_n and cd.
//
// state   | meaning
// IDLE    | waiting for req; mode keeps its last value, cd released
// SETUP   | mode/cd stable before the strobe falls
// STROBE  | csw_n or csr_n held low
// HOLD    | strobe high, mode/cd still held
// RECOVER | both strobes high, cd released, before ack
module vdp_bus_master #(
    parameter int SETUP_CYC    = 2,
    parameter int STROBE_CYC   = 8,
    parameter int HOLD_CYC     = 2,
    parameter int RECOVERY_CYC = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req,
    input  logic       wr,
    input  logic [1:0] port,
    input  logic [7:0] wdata,
    output logic       ack,
    output logic [7:0] rdata,
    output logic       busy,
    output logic [1:0] mode,
    output logic       csw_n,
    output logic       csr_n,
    output logic [7:0] cd_o,
    output logic       cd_oe,
    input  logic [7:0] cd_i
);

    localparam int MAX_AB  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
    localparam int MAX_CD  = (HOLD_CYC > RECOVERY_CYC) ? HOLD_CYC : RECOVERY_CYC;
    localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC + 1) : 1;

    localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYC - 1);
    // The ack cycle itself is the last recovery cycle, so RECOVER proper is one shorter.
    localparam logic [CW-1:0] RECOV_LD  = CW'((RECOVERY_CYC > 1) ? RECOVERY_CYC - 2 : 0);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STROBE  = 3'd2,
        HOLD    = 3'd3,
        RECOVER = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            wr_q, wr_d;
    logic            ack_q, ack_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            busy_q, busy_d;
    logic [1:0]      mode_q, mode_d;
    logic            csw_n_q, csw_n_d;
    logic            csr_n_q, csr_n_d;
    logic [7:0]      cd_o_q, cd_o_d;
    logic            cd_oe_q, cd_oe_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        ack_d   = 1'b0;
        rdata_d = rdata_q;
        busy_d  = busy_q;
        mode_d  = mode_q;
        csw_n_d = csw_n_q;
        csr_n_d = csr_n_q;
        cd_o_d  = cd_o_q;
        cd_oe_d = cd_oe_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    wr_d    = wr;
                    mode_d  = port;
                    cd_o_d  = wdata;
                    cd_oe_d = wr;
                    busy_d  = 1'b1;
                    cnt_d   = SETUP_LD;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    csw_n_d = ~wr_q;
                    csr_n_d = wr_q;
                    cnt_d   = STROBE_LD;
                    state_d = STROBE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            STROBE: begin
                if (cnt_q == '0) begin
                    if (!wr_q) begin
                        rdata_d = cd_i;
                    end
                    csw_n_d = 1'b1;
                    csr_n_d = 1'b1;
                    cnt_d   = HOLD_LD;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    cd_oe_d = 1'b0;
                    if (RECOVERY_CYC == 1) begin
                        ack_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        cnt_d   = RECOV_LD;
                        state_d = RECOVER;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RECOVER: begin
                if (cnt_q == '0) begin
                    ack_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                csw_n_d = 1'b1;
                csr_n_d = 1'b1;
                cd_oe_d = 1'b0;
                busy_d  = 1'b0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            ack_q   <= 1'b0;
            rdata_q <= 8'h00;
            busy_q  <= 1'b0;
            mode_q  <= 2'd0;
            csw_n_q <= 1'b1;
            csr_n_q <= 1'b1;
            cd_o_q  <= 8'h00;
            cd_oe_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            mode_q  <= mode_d;
            csw_n_q <= csw_n_d;
            csr_n_q <= csr_n_d;
            cd_o_q  <= cd_o_d;
            cd_oe_q <= cd_oe_d;
        end
    end

    assign ack   = ack_q;
    assign rdata = rdata_q;
    assign busy  = busy_q;
    assign mode  = mode_q;
    assign csw_n = csw_n_q;
    assign csr_n = csr_n_q;
    assign cd_o  = cd_o_q;
    assign cd_oe = cd_oe_q;

endmodule

// File: tb/tb_vdp_bus_master.sv
// Scoreboard bench for vdp_bus_master: stimulus pushes expected transactions,
// a negedge monitor checks bus timing and rdata whenever ack is seen.
module tb_vdp_bus_master;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       req = 1'b0;
    logic       wr = 1'b0;
    logic [1:0] port = 2'd0;
    logic [7:0] wdata = 8'h00;
    logic       ack;
    logic [7:0] rdata;
    logic       busy;
    logic [1:0] mode;
    logic       csw_n;
    logic       csr_n;
    logic [7:0] cd_o;
    logic       cd_oe;
    logic [7:0] cd_i;
    logic [7:0] resp_val = 8'h00;

    // Responder model: drives its data only while the read strobe is low.
    assign cd_i = csr_n ? 8'h00 : resp_val;

    always #5 clk = ~clk;

    vdp_bus_master dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .wr      (wr),
        .port    (port),
        .wdata   (wdata),
        .ack     (ack),
        .rdata   (rdata),
        .busy    (busy),
        .mode    (mode),
        .csw_n   (csw_n),
        .csr_n   (csr_n),
        .cd_o    (cd_o),
        .cd_oe   (cd_oe),
        .cd_i    (cd_i)
    );

    typedef struct {
        logic       wr;
        logic [1:0] port;
        logic [7:0] wdata;
        logic [7:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   gap_q[$];
    int   ack_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_ack = 0;
    int   n_strobe = 0;
    int   cyc_abs = 0;
    logic [7:0] last_rd = 8'h00;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor state, cycles counted from the first busy cycle (tcyc = 1).
    int   tcyc = 0, s_first = 0, s_last = 0, s_kind = 0, oe_first = 0, oe_last = 0;
    int   last_low_abs = 0;
    bit   mode_bad = 0, cd_bad = 0, both_bad = 0, prev_low = 0, ack_prev = 0, low = 0;
    exp_t cur;

    always @(negedge clk) begin
        cyc_abs++;
        if (ack_prev) chk("ack_single_cycle", int'(ack), 0);
        ack_prev = ack;
        if (!reset_n) begin
            tcyc     = 0;
            prev_low = 0;
        end else begin
            if (busy && tcyc == 0) begin
                tcyc = 1; s_first = 0; s_last = 0; s_kind = 0; oe_first = 0; oe_last = 0;
                mode_bad = 0; cd_bad = 0; both_bad = 0;
            end else if (tcyc > 0) begin
                tcyc++;
            end
            low = !csw_n || !csr_n;
            if (!csw_n && !csr_n) both_bad = 1;
            if (low && !prev_low) begin
                n_strobe++;
                if (last_low_abs > 0) gap_q.push_back(cyc_abs - last_low_abs - 1);
            end
            if (low) last_low_abs = cyc_abs;
            prev_low = low;
            if (tcyc > 0 && low) begin
                if (s_first == 0) begin
                    s_first = tcyc;
                    s_kind  = !csw_n ? 1 : 2;
                end
                s_last = tcyc;
            end
            if (tcyc > 0 && cd_oe) begin
                if (oe_first == 0) oe_first = tcyc;
                oe_last = tcyc;
            end
            if (tcyc > 0 && tcyc <= 12 && exp_q.size() > 0) begin
                if (mode != exp_q[0].port) mode_bad = 1;
                if (exp_q[0].wr && cd_o != exp_q[0].wdata) cd_bad = 1;
            end
            if (ack) begin
                n_ack++;
                ack_q.push_back(cyc_abs);
                if (exp_q.size() == 0) begin
                    chk("ack_expected", 0, 1);
                end else begin
                    cur = exp_q.pop_front();
                    chk("ack_cycle", tcyc, 20);
                    chk("strobe_kind", s_kind, cur.wr ? 1 : 2);
                    chk("strobe_first", s_first, 3);
                    chk("strobe_last", s_last, 10);
                    chk("strobes_both_low", int'(both_bad), 0);
                    chk("mode_stable", int'(mode_bad), 0);
                    if (cur.wr) begin
                        chk("cd_o_stable", int'(cd_bad), 0);
                        chk("cd_oe_first", oe_first, 1);
                        chk("cd_oe_last", oe_last, 12);
                    end else begin
                        chk("cd_oe_read", oe_first, 0);
                    end
                    chk("rdata", int'(rdata), int'(cur.rdata));
                end
                tcyc = 0;
            end
        end
    end

    task automatic issue(input logic w, input logic [1:0] p, input logic [7:0] d,
                         input logic [7:0] r, input bit push);
        exp_t e;
        @(negedge clk); #1;
        req = 1'b1; wr = w; port = p; wdata = d;
        if (push) begin
            e.wr = w; e.port = p; e.wdata = d; e.rdata = r;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic push_exp(input logic w, input logic [1:0] p, input logic [7:0] d,
                            input logic [7:0] r);
        exp_t e;
        e.wr = w; e.port = p; e.wdata = d; e.rdata = r;
        exp_q.push_back(e);
    endtask

    task automatic wait_acks(input int target, input string name);
        int k;
        k = 0;
        while (n_ack < target && k < 100) begin
            @(negedge clk); #1;
            k++;
        end
        chk(name, int'(n_ack >= target), 1);
    endtask

    int base_ack, base_strobe;

    initial begin
        // Reset values, both under reset and after 10 idle cycles.
        #12;
        chk("rst_csw_n", int'(csw_n), 1);
        chk("rst_csr_n", int'(csr_n), 1);
        chk("rst_cd_oe", int'(cd_oe), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ack", int'(ack), 0);
        chk("rst_rdata", int'(rdata), 0);
        chk("rst_cd_o", int'(cd_o), 0);
        @(negedge clk); #1;
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_csw_n", int'(csw_n), 1);
        chk("idle_csr_n", int'(csr_n), 1);
        chk("idle_cd_oe", int'(cd_oe), 0);
        chk("idle_busy", int'(busy), 0);
        chk("idle_ack", int'(ack), 0);
        chk("idle_mode", int'(mode), 0);

        // Single write, then reads (rdata held; late change on last strobe cycle).
        issue(1'b1, 2'd1, 8'h87, last_rd, 1);
        wait_acks(1, "write_done");

        resp_val = 8'h9F;
        issue(1'b0, 2'd1, 8'h00, 8'h9F, 1);
        wait_acks(2, "read_done");
        last_rd = 8'h9F;
        resp_val = 8'h00;
        repeat (5) @(negedge clk);
        chk("rdata_held", int'(rdata), 8'h9F);

        resp_val = 8'h11;
        issue(1'b0, 2'd2, 8'h00, 8'h5A, 1);
        repeat (9) @(posedge clk);
        #1 resp_val = 8'h5A;
        wait_acks(3, "read_late_done");
        last_rd = 8'h5A;

        issue(1'b1, 2'd2, 8'h3C, last_rd, 1);
        wait_acks(4, "write_keeps_rdata_done");

        // req held high across three writes.
        gap_q.delete();
        ack_q.delete();
        base_ack = n_ack;
        @(negedge clk); #1;
        req = 1'b1; wr = 1'b1; port = 2'd0; wdata = 8'h01;
        push_exp(1'b1, 2'd0, 8'h01, last_rd);
        wait_acks(base_ack + 1, "b2b_ack1");
        wdata = 8'h02;
        push_exp(1'b1, 2'd0, 8'h02, last_rd);
        wait_acks(base_ack + 2, "b2b_ack2");
        wdata = 8'h03;
        push_exp(1'b1, 2'd0, 8'h03, last_rd);
        @(posedge clk); #1;
        req = 1'b0;
        wait_acks(base_ack + 3, "b2b_ack3");
        chk("b2b_gap_count", gap_q.size(), 3);
        if (gap_q.size() == 3) begin
            chk("b2b_gap1", gap_q[1], 12);
            chk("b2b_gap2", gap_q[2], 12);
        end
        chk("b2b_ack_count", ack_q.size(), 3);
        if (ack_q.size() == 3) begin
            chk("b2b_ack_spacing1", ack_q[1] - ack_q[0], 20);
            chk("b2b_ack_spacing2", ack_q[2] - ack_q[1], 20);
        end

        // req and input changes during STROBE are ignored.
        repeat (3) @(negedge clk);
        base_ack = n_ack;
        base_strobe = n_strobe;
        issue(1'b1, 2'd3, 8'hA5, last_rd, 1);
        repeat (4) @(negedge clk);
        #1;
        req = 1'b1; wr = 1'b0; port = 2'd0; wdata = 8'hFF;
        @(posedge clk); #1;
        req = 1'b0;
        wait_acks(base_ack + 1, "ignore_ack");
        repeat (30) @(negedge clk);
        chk("ignore_ack_count", n_ack - base_ack, 1);
        chk("ignore_strobe_count", n_strobe - base_strobe, 1);

        // Reset during the write strobe: abandoned with no ack.
        base_ack = n_ack;
        issue(1'b1, 2'd2, 8'h44, 8'h00, 0);
        repeat (4) @(negedge clk);
        chk("abort_in_strobe", int'(csw_n), 0);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_csw_n", int'(csw_n), 1);
        chk("abort_cd_oe", int'(cd_oe), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_ack", int'(ack), 0);
        chk("abort_mode", int'(mode), 0);
        chk("abort_rdata", int'(rdata), 0);
        last_rd = 8'h00;
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("abort_no_ack", n_ack - base_ack, 0);

        issue(1'b1, 2'd1, 8'h5C, last_rd, 1);
        wait_acks(base_ack + 1, "post_reset_write");
        resp_val = 8'h77;
        issue(1'b0, 2'd2, 8'h00, 8'h77, 1);
        wait_acks(base_ack + 2, "post_reset_read");

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
